// File: rtl/id_ex_mem_ctrl_pipe_pkg.sv
// Shared opcode, ALU-op and control encodings for the decode / ID-EX / EX-MEM slice.
// The optional flush feature is enabled by defining PIPE_FLUSH_EN.
package id_ex_mem_ctrl_pipe_pkg;

    localparam int CTRL_ALU_W = 5;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SLL  = 6'h06;
    localparam logic [5:0] OP_SRL  = 6'h07;
    localparam logic [5:0] OP_MUL  = 6'h08;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_SUBI = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h0B;
    localparam logic [5:0] OP_SW   = 6'h0C;
    localparam logic [5:0] OP_LI   = 6'h0D;
    localparam logic [5:0] OP_B    = 6'h0E;

    localparam logic [CTRL_ALU_W-1:0] ALU_ADD = 5'd0;
    localparam logic [CTRL_ALU_W-1:0] ALU_SUB = 5'd1;
    localparam logic [CTRL_ALU_W-1:0] ALU_AND = 5'd2;
    localparam logic [CTRL_ALU_W-1:0] ALU_OR  = 5'd3;
    localparam logic [CTRL_ALU_W-1:0] ALU_XOR = 5'd4;
    localparam logic [CTRL_ALU_W-1:0] ALU_SLL = 5'd5;
    localparam logic [CTRL_ALU_W-1:0] ALU_SRL = 5'd6;
    localparam logic [CTRL_ALU_W-1:0] ALU_MUL = 5'd7;

    localparam logic [1:0] M2R_MEM = 2'b00;
    localparam logic [1:0] M2R_ALU = 2'b01;
    localparam logic [1:0] M2R_IMM = 2'b10;

    localparam logic [1:0] IMM_10 = 2'b00;
    localparam logic [1:0] IMM_15 = 2'b01;
    localparam logic [1:0] IMM_20 = 2'b10;

    typedef struct packed {
        logic [CTRL_ALU_W-1:0] alu_control;
        logic                  alu_src;
        logic [1:0]            imm_src;
        logic [1:0]            mem_to_reg;
        logic                  mem_write;
        logic                  reg_write;
        logic                  pc_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_mem_ctrl_pipe_ctrl_decode.sv
// Combinational opcode decoder; NOP and undefined opcodes yield all-zero controls.
module id_ex_mem_ctrl_pipe_ctrl_decode
    import id_ex_mem_ctrl_pipe_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL: begin
                // Register-register ops map opcode 1..8 onto ALU op 0..7.
                ctrl.alu_control = CTRL_ALU_W'(opcode - 6'd1);
                ctrl.mem_to_reg  = M2R_ALU;
                ctrl.reg_write   = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_control = ALU_ADD;
                ctrl.alu_src     = 1'b1;
                ctrl.imm_src     = IMM_10;
                ctrl.mem_to_reg  = M2R_ALU;
                ctrl.reg_write   = 1'b1;
            end
            OP_SUBI: begin
                ctrl.alu_control = ALU_SUB;
                ctrl.alu_src     = 1'b1;
                ctrl.imm_src     = IMM_10;
                ctrl.mem_to_reg  = M2R_ALU;
                ctrl.reg_write   = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_control = ALU_ADD;
                ctrl.alu_src     = 1'b1;
                ctrl.imm_src     = IMM_10;
                ctrl.mem_to_reg  = M2R_MEM;
                ctrl.reg_write   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_control = ALU_ADD;
                ctrl.alu_src     = 1'b1;
                ctrl.imm_src     = IMM_10;
                ctrl.mem_write   = 1'b1;
            end
            OP_LI: begin
                ctrl.imm_src    = IMM_20;
                ctrl.mem_to_reg = M2R_IMM;
                ctrl.reg_write  = 1'b1;
            end
            OP_B: begin
                ctrl.pc_src  = 1'b1;
                ctrl.imm_src = IMM_15;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_mem_ctrl_pipe.sv
// Decode control plus ID/EX and EX/MEM pipeline registers; every stage loads every cycle.
// Define PIPE_FLUSH_EN to add a flush input that bubbles the ID/EX controls.
module id_ex_mem_ctrl_pipe
    import id_ex_mem_ctrl_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ALU_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_sign_imm,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              pc_src,
    output logic [1:0]        imm_src,
    output logic [1:0]        ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_alu_src,
    output logic [ALU_W-1:0]  ex_alu_control,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_sign_imm,
    output logic [4:0]        ex_rd,
    output logic [1:0]        mem_mem_to_reg,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [DATA_W-1:0] mem_sign_imm,
    output logic [4:0]        mem_rd
);

    ctrl_t dec;

    id_ex_mem_ctrl_pipe_ctrl_decode u_ctrl_decode (
        .opcode (opcode),
        .ctrl   (dec)
    );

    assign pc_src  = dec.pc_src;
    assign imm_src = dec.imm_src;

    logic [1:0]        ex_mem_to_reg_d,  ex_mem_to_reg_q;
    logic              ex_mem_write_d,   ex_mem_write_q;
    logic              ex_reg_write_d,   ex_reg_write_q;
    logic              ex_alu_src_d,     ex_alu_src_q;
    logic [ALU_W-1:0]  ex_alu_control_d, ex_alu_control_q;
    logic [DATA_W-1:0] ex_pc_d,          ex_pc_q;
    logic [DATA_W-1:0] ex_rd1_d,         ex_rd1_q;
    logic [DATA_W-1:0] ex_rd2_d,         ex_rd2_q;
    logic [DATA_W-1:0] ex_sign_imm_d,    ex_sign_imm_q;
    logic [4:0]        ex_rd_d,          ex_rd_q;

    logic [1:0]        mem_mem_to_reg_d, mem_mem_to_reg_q;
    logic              mem_mem_write_d,  mem_mem_write_q;
    logic              mem_reg_write_d,  mem_reg_write_q;
    logic [DATA_W-1:0] mem_alu_result_d, mem_alu_result_q;
    logic [DATA_W-1:0] mem_store_data_d, mem_store_data_q;
    logic [DATA_W-1:0] mem_sign_imm_d,   mem_sign_imm_q;
    logic [4:0]        mem_rd_d,         mem_rd_q;

    always_comb begin
        ex_mem_to_reg_d  = dec.mem_to_reg;
        ex_mem_write_d   = dec.mem_write;
        ex_reg_write_d   = dec.reg_write;
        ex_alu_src_d     = dec.alu_src;
        ex_alu_control_d = ALU_W'(dec.alu_control);
`ifdef PIPE_FLUSH_EN
        // Flush kills only the controls; operand data still flows so EX stays deterministic.
        if (flush) begin
            ex_mem_to_reg_d  = '0;
            ex_mem_write_d   = 1'b0;
            ex_reg_write_d   = 1'b0;
            ex_alu_src_d     = 1'b0;
            ex_alu_control_d = '0;
        end
`endif
        ex_pc_d       = id_pc;
        ex_rd1_d      = id_rd1;
        ex_rd2_d      = id_rd2;
        ex_sign_imm_d = id_sign_imm;
        ex_rd_d       = id_rd;

        mem_mem_to_reg_d = ex_mem_to_reg_q;
        mem_mem_write_d  = ex_mem_write_q;
        mem_reg_write_d  = ex_reg_write_q;
        mem_alu_result_d = ex_alu_result;
        mem_store_data_d = ex_store_data;
        mem_sign_imm_d   = ex_sign_imm_q;
        mem_rd_d         = ex_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_to_reg_q  <= '0;
            ex_mem_write_q   <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_alu_src_q     <= 1'b0;
            ex_alu_control_q <= '0;
            ex_pc_q          <= '0;
            ex_rd1_q         <= '0;
            ex_rd2_q         <= '0;
            ex_sign_imm_q    <= '0;
            ex_rd_q          <= '0;
        end else begin
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_reg_write_q   <= ex_reg_write_d;
            ex_alu_src_q     <= ex_alu_src_d;
            ex_alu_control_q <= ex_alu_control_d;
            ex_pc_q          <= ex_pc_d;
            ex_rd1_q         <= ex_rd1_d;
            ex_rd2_q         <= ex_rd2_d;
            ex_sign_imm_q    <= ex_sign_imm_d;
            ex_rd_q          <= ex_rd_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_mem_to_reg_q <= '0;
            mem_mem_write_q  <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_alu_result_q <= '0;
            mem_store_data_q <= '0;
            mem_sign_imm_q   <= '0;
            mem_rd_q         <= '0;
        end else begin
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_store_data_q <= mem_store_data_d;
            mem_sign_imm_q   <= mem_sign_imm_d;
            mem_rd_q         <= mem_rd_d;
        end
    end

    assign ex_mem_to_reg  = ex_mem_to_reg_q;
    assign ex_mem_write   = ex_mem_write_q;
    assign ex_reg_write   = ex_reg_write_q;
    assign ex_alu_src     = ex_alu_src_q;
    assign ex_alu_control = ex_alu_control_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rd1         = ex_rd1_q;
    assign ex_rd2         = ex_rd2_q;
    assign ex_sign_imm    = ex_sign_imm_q;
    assign ex_rd          = ex_rd_q;

    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_store_data = mem_store_data_q;
    assign mem_sign_imm   = mem_sign_imm_q;
    assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_id_ex_mem_ctrl_pipe.sv
// Self-checking bench for id_ex_mem_ctrl_pipe: directed plan cases plus a random stream
// checked against a queue of decoded instructions (one entry per clock edge).
module tb_id_ex_mem_ctrl_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [5:0]    opcode = '0;
  logic [DW-1:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_sign_imm = '0;
  logic [4:0]    id_rd = '0;
  logic [DW-1:0] ex_alu_result = '0, ex_store_data = '0;

  logic          pc_src;
  logic [1:0]    imm_src;
  logic [1:0]    ex_mem_to_reg;
  logic          ex_mem_write, ex_reg_write, ex_alu_src;
  logic [AW-1:0] ex_alu_control;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_sign_imm;
  logic [4:0]    ex_rd;
  logic [1:0]    mem_mem_to_reg;
  logic          mem_mem_write, mem_reg_write;
  logic [DW-1:0] mem_alu_result, mem_store_data, mem_sign_imm;
  logic [4:0]    mem_rd;

  id_ex_mem_ctrl_pipe #(.DATA_W(DW), .ALU_W(AW)) dut (
    .clk(clk), .rst(rst),
`ifdef PIPE_FLUSH_EN
    .flush(flush),
`endif
    .opcode(opcode), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_sign_imm(id_sign_imm), .id_rd(id_rd),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .pc_src(pc_src), .imm_src(imm_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_alu_control(ex_alu_control), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_sign_imm(ex_sign_imm), .ex_rd(ex_rd),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_sign_imm(mem_sign_imm), .mem_rd(mem_rd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference decode, straight from the opcode table
  typedef struct packed {
    logic [4:0] alu; logic alu_src; logic [1:0] imm_src; logic [1:0] m2r;
    logic mw; logic rw; logic pc;
  } ref_ctrl_t;

  typedef struct {
    ref_ctrl_t     c;
    logic [DW-1:0] pc, rd1, rd2, imm, alu_in, st_in;
    logic [4:0]    rd;
  } rec_t;

  function automatic ref_ctrl_t ref_dec(input logic [5:0] op);
    ref_ctrl_t r;
    r = '0;
    if (op >= 6'h01 && op <= 6'h08) begin
      r.alu = 5'(op) - 5'd1; r.m2r = 2'b01; r.rw = 1'b1;
    end else if (op == 6'h09 || op == 6'h0A || op == 6'h0B || op == 6'h0C) begin
      r.alu_src = 1'b1; r.imm_src = 2'b00;
      r.alu = (op == 6'h0A) ? 5'd1 : 5'd0;
      r.m2r = (op == 6'h0B) ? 2'b00 : (op == 6'h0C) ? 2'b00 : 2'b01;
      r.rw  = (op != 6'h0C);
      r.mw  = (op == 6'h0C);
    end else if (op == 6'h0D) begin
      r.imm_src = 2'b10; r.m2r = 2'b10; r.rw = 1'b1;
    end else if (op == 6'h0E) begin
      r.pc = 1'b1; r.imm_src = 2'b01;
    end
    return r;
  endfunction

  // scoreboard
  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_pipe();
    rec_t e, m;
    e = '{c: '0, pc: '0, rd1: '0, rd2: '0, imm: '0, alu_in: '0, st_in: '0, rd: '0};
    m = e;
    if (exp_q.size() >= 1) e = exp_q[$];
    if (exp_q.size() >= 2) m = exp_q[$-1];
    check("ex_alu_control", 64'(ex_alu_control), 64'(e.c.alu));
    check("ex_alu_src",     64'(ex_alu_src),     64'(e.c.alu_src));
    check("ex_mem_to_reg",  64'(ex_mem_to_reg),  64'(e.c.m2r));
    check("ex_mem_write",   64'(ex_mem_write),   64'(e.c.mw));
    check("ex_reg_write",   64'(ex_reg_write),   64'(e.c.rw));
    check("ex_pc",          64'(ex_pc),          64'(e.pc));
    check("ex_rd1",         64'(ex_rd1),         64'(e.rd1));
    check("ex_rd2",         64'(ex_rd2),         64'(e.rd2));
    check("ex_sign_imm",    64'(ex_sign_imm),    64'(e.imm));
    check("ex_rd",          64'(ex_rd),          64'(e.rd));
    check("mem_mem_to_reg", 64'(mem_mem_to_reg), 64'(m.c.m2r));
    check("mem_mem_write",  64'(mem_mem_write),  64'(m.c.mw));
    check("mem_reg_write",  64'(mem_reg_write),  64'(m.c.rw));
    check("mem_sign_imm",   64'(mem_sign_imm),   64'(m.imm));
    check("mem_rd",         64'(mem_rd),         64'(m.rd));
    // EX-stage inputs sampled at the most recent edge land in MEM directly
    check("mem_alu_result", 64'(mem_alu_result), 64'(e.alu_in));
    check("mem_store_data", 64'(mem_store_data), 64'(e.st_in));
  endtask

  // driver: apply one decode-stage instruction at negedge, clock it in, check after the edge
  task automatic step(input logic [5:0] op, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                      input logic [DW-1:0] imm, input logic [4:0] rd,
                      input logic [DW-1:0] alu_in, input logic [DW-1:0] st_in,
                      input logic fl);
    rec_t r;
    ref_ctrl_t c;
    opcode = op; id_rd1 = rd1; id_rd2 = rd2; id_sign_imm = imm; id_rd = rd;
    id_pc = $urandom(); ex_alu_result = alu_in; ex_store_data = st_in; flush = fl;
    #1;
    c = ref_dec(op);
    check("pc_src",  64'(pc_src),  64'(c.pc));
    check("imm_src", 64'(imm_src), 64'(c.imm_src));
`ifdef PIPE_FLUSH_EN
    if (fl) begin
      c.alu = '0; c.alu_src = 1'b0; c.m2r = '0; c.mw = 1'b0; c.rw = 1'b0;
    end
`endif
    r = '{c: c, pc: id_pc, rd1: rd1, rd2: rd2, imm: imm, alu_in: alu_in, st_in: st_in, rd: rd};
    @(posedge clk);
    if (rst) exp_q.delete();
    else begin
      exp_q.push_back(r);
      if (exp_q.size() > 2) void'(exp_q.pop_front());
    end
    @(negedge clk);
    check_pipe();
  endtask

  task automatic step_rand();
    logic [5:0] op;
    op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'($urandom_range(0, 14));
    step(op, $urandom(), $urandom(), $urandom(), 5'($urandom()), $urandom(), $urandom(),
         ($urandom_range(0, 5) == 0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_pipe();
    rst = 1'b0;

    // ADD: rd1=5, rd2=7, rd=3
    step(6'h01, 32'd5, 32'd7, 32'd0, 5'd3, 32'd0, 32'd0, 1'b0);
    check("add_ex_reg_write", 64'(ex_reg_write), 64'd1);
    check("add_ex_m2r",       64'(ex_mem_to_reg), 64'd1);
    check("add_ex_rd1",       64'(ex_rd1), 64'd5);
    // SW in decode, ADD in EX
    step(6'h0C, 32'd1, 32'd2, 32'd4, 5'd9, 32'd0, 32'd0, 1'b0);
    check("add_mem_reg_write", 64'(mem_reg_write), 64'd1);
    check("add_mem_rd",        64'(mem_rd), 64'd3);
    // LI in decode, SW in EX with its ALU/store results
    step(6'h0D, 32'd0, 32'd0, 32'h000ABCDE, 5'd4, 32'h10, 32'hDEADBEEF, 1'b0);
    check("sw_mem_mem_write",  64'(mem_mem_write), 64'd1);
    check("sw_mem_reg_write",  64'(mem_reg_write), 64'd0);
    check("sw_mem_store_data", 64'(mem_store_data), 64'hDEADBEEF);
    check("sw_mem_alu_result", 64'(mem_alu_result), 64'h10);
    step(6'h0E, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    check("li_mem_m2r", 64'(mem_mem_to_reg), 64'd2);
    check("li_mem_imm", 64'(mem_sign_imm), 64'h000ABCDE);
    step(6'h3F, 32'd1, 32'd1, 32'd1, 5'd1, 32'd0, 32'd0, 1'b0);
    step(6'h00, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);

    // back-to-back ADD / LW / SW / NOP
    for (int i = 0; i < 8; i++) begin
      logic [5:0] ops [4];
      ops = '{6'h01, 6'h0B, 6'h0C, 6'h00};
      step(ops[i % 4], $urandom(), $urandom(), $urandom(), 5'(i + 1), $urandom(), $urandom(), 1'b0);
    end

    for (int i = 0; i < 120; i++) step_rand();

    // asynchronous mid-stream reset, asserted away from any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_ex_reg_write",  64'(ex_reg_write), 64'd0);
    check("rst_ex_rd1",        64'(ex_rd1), 64'd0);
    check("rst_mem_reg_write", 64'(mem_reg_write), 64'd0);
    check("rst_mem_alu",       64'(mem_alu_result), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check_pipe();
    step(6'h01, 32'd9, 32'd9, 32'd9, 5'd9, 32'd9, 32'd9, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 150; i++) step_rand();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_mem_ctrl_pipe.md
Name: id_ex_mem_ctrl_pipe

Overview:
Decode-stage control unit plus the ID/EX and EX/MEM pipeline registers of the 5-stage 32-bit core.
- Decodes the 6-bit opcode into datapath controls.
- Registers decode-stage operands and controls into EX.
- Registers EX results and the remaining controls into MEM.
- The external ALU and source-B mux sit between the two register stages.

Parameters:
DATA_W, 32, datapath/register width
ALU_W, 5, alu_control width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
opcode  in  6  opcode of instruction in decode
id_pc  in  DATA_W  PC of decode instruction
id_rd1  in  DATA_W  register file read port 1
id_rd2  in  DATA_W  register file read port 2
id_sign_imm  in  DATA_W  extended immediate
id_rd  in  5  destination register
ex_alu_result  in  DATA_W  ALU output in EX
ex_store_data  in  DATA_W  source-B mux output in EX
pc_src  out  1  combinational: take branch (decode stage)
imm_src  out  2  combinational: 00 imm10, 01 imm15, 10 imm20
ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_alu_src  out  2/1/1/1  ID/EX control
ex_alu_control  out  ALU_W  ID/EX ALU operation
ex_pc, ex_rd1, ex_rd2, ex_sign_imm  out  DATA_W each  ID/EX data
ex_rd  out  5  ID/EX destination
mem_mem_to_reg, mem_mem_write, mem_reg_write  out  2/1/1  EX/MEM control
mem_alu_result, mem_store_data, mem_sign_imm  out  DATA_W each  EX/MEM data
mem_rd  out  5  EX/MEM destination

Behaviour:
- Decode is purely combinational; fields are {alu_control, alu_src, imm_src, mem_to_reg, mem_write, reg_write, pc_src}.
- mem_to_reg encoding: 00 memory data, 01 ALU result, 10 sign_imm.
- Register-register ops (alu_src 0, mem_to_reg 01, reg_write 1):
  - 0x01 ADD: alu_control 0
  - 0x02 SUB: 1
  - 0x03 AND: 2
  - 0x04 OR: 3
  - 0x05 XOR: 4
  - 0x06 SLL: 5
  - 0x07 SRL: 6
  - 0x08 MUL: 7
- Immediate ops (alu_src 1, imm_src 00):
  - 0x09 ADDI: ADD, mem_to_reg 01, reg_write 1
  - 0x0A SUBI: SUB, mem_to_reg 01, reg_write 1
  - 0x0B LW: ADD, mem_to_reg 00, reg_write 1
  - 0x0C SW: ADD, mem_write 1, reg_write 0
- 0x0D LI: imm_src 10, mem_to_reg 10, reg_write 1.
- 0x0E B: pc_src 1, imm_src 01, reg_write 0.
- 0x00 NOP and every undefined opcode decode to all-zero controls; such instructions never write the register file or memory.
- ID/EX: on each rising edge, captures the decoded controls and id_* data → ex_* (1-cycle latency).
- EX/MEM: on each rising edge, captures:
  - ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_sign_imm, ex_rd
  - ex_alu_result and ex_store_data → mem_*
- Controls therefore reach mem_* outputs 2 cycles after decode.
- No stall or enable: every stage loads every cycle.
- rst asserted (any time, including mid-stream) immediately clears every registered output to 0, which is a NOP bubble.
- First capture occurs on the first rising edge after rst deasserts.
- pc_src and imm_src follow opcode regardless of rst.

Optional Feature:
PIPE_FLUSH_EN:
- Defined: adds input flush (1 bit).
  - flush=1 at a rising edge loads ID/EX controls with zeros: mem_write, reg_write, alu_src, alu_control, mem_to_reg all 0.
  - ID/EX data fields still capture normally.
  - EX/MEM is unaffected.
- Undefined: no port, no flush logic.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP..OP_B)
  - ALU op codes
  - mem_to_reg and imm_src encodings
  - a packed ctrl_t struct of the decoded fields
- Natural sub-module: ctrl_decode, the combinational opcode→ctrl_t decoder, instantiated once.
- Both pipeline registers live in the top module as always_ff blocks.

Test Plan:
- Reset: rst=1 mid-stream → all ex_*/mem_* read 0 immediately, asynchronously to clk.
- opcode 0x01, id_rd1=5, id_rd2=7, id_rd=3 → next edge:
  - ex_alu_control=0, ex_reg_write=1, ex_mem_to_reg=01, ex_rd1=5, ex_rd=3
  - one edge later: mem_reg_write=1, mem_rd=3
- opcode 0x0C with ex_store_data=0xDEADBEEF and ex_alu_result=0x10 present during EX → mem_mem_write=1, mem_reg_write=0, mem_store_data=0xDEADBEEF, mem_alu_result=0x10.
- opcode 0x0D, id_sign_imm=0x000ABCDE:
  - imm_src=10 combinationally
  - 2 edges later: mem_mem_to_reg=10, mem_sign_imm=0x000ABCDE
- opcode 0x0E → pc_src=1 and imm_src=01 same cycle; opcode 0x3F → all controls 0.
- Back-to-back ADD/LW/SW/NOP stream → each instruction's controls appear on ex_* at +1 and mem_* at +2 edges, with no cross-instruction mixing.
